// File: rtl/coproc_sequencer_pkg.sv
// ============================================================================
// Module      : coproc_sequencer_pkg
// Description : Opcodes, FSM encoding and width helpers shared by the
//               coprocessor sequencer and its output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package coproc_sequencer_pkg;

    localparam logic [2:0] OP_ADD     = 3'd0;
    localparam logic [2:0] OP_SUB     = 3'd1;
    localparam logic [2:0] OP_MUL     = 3'd2;
    localparam logic [2:0] OP_SMUL    = 3'd3;
    localparam logic [2:0] OP_TRANSP  = 3'd4;
    localparam logic [2:0] OP_OPP     = 3'd5;
    localparam logic [2:0] OP_DET     = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    // RES_W: width of one coprocessor result element
    function automatic int res_w(input int width);
        return 2 * width + 3;
    endfunction

    // DET_W: width of the determinant and of every output word
    function automatic int det_w(input int width);
        return 3 * width + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/coproc_seq_outbuf.sv
// ============================================================================
// Module      : coproc_seq_outbuf
// Description : Captures the coprocessor result/determinant and presents one
//               sign-extended word at a time, row-major.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coproc_seq_outbuf
    import coproc_sequencer_pkg::*;
#(
    parameter int N     = 3,
    parameter int WIDTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           capture_i,
    input  logic                           advance_i,
    input  logic                           det_mode_i,
    input  logic [N*N*res_w(WIDTH)-1:0]    res_i,
    input  logic [det_w(WIDTH)-1:0]        det_i,
    output logic [det_w(WIDTH)-1:0]        data_o,
    output logic                           last_o
);

    localparam int c_NN    = N * N;
    localparam int c_RES_W = res_w(WIDTH);
    localparam int c_DET_W = det_w(WIDTH);
    localparam int c_IDX_W = $clog2(c_NN + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NN - 1);

    logic [c_NN*c_RES_W-1:0] res_q;
    logic [c_DET_W-1:0]      det_q;
    logic [c_IDX_W-1:0]      widx_q;
    logic [c_RES_W-1:0]      elem;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_q  <= '0;
            det_q  <= '0;
            widx_q <= '0;
        end else if (capture_i) begin
            res_q  <= res_i;
            det_q  <= det_i;
            widx_q <= '0;
        end else if (advance_i && (widx_q != c_LAST_IDX)) begin
            // Index saturates on the last word so the selector never leaves range
            widx_q <= widx_q + 1'b1;
        end
    end

    always_comb begin
        elem   = res_q[(c_NN - int'(widx_q))*c_RES_W - 1 -: c_RES_W];
        data_o = det_mode_i ? det_q
                            : {{(c_DET_W-c_RES_W){elem[c_RES_W-1]}}, elem};
        last_o = det_mode_i || (widx_q == c_LAST_IDX);
    end

endmodule

`default_nettype wire

// File: rtl/coproc_sequencer.sv
// ============================================================================
// Module      : coproc_sequencer
// Description : Command/load/execute/output sequencer for an external matrix
//               coprocessor. Define COPROC_SEQ_SKIP_B_EN to skip loading B
//               for the single-operand ops (scalar-mul, transpose, opposite,
//               determinant).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coproc_sequencer
    import coproc_sequencer_pkg::*;
#(
    parameter int N      = 3,
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic                           CLOCK_50,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [2:0]                     cmd_op,
    input  logic [WIDTH-1:0]               cmd_escalar,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [det_w(WIDTH)-1:0]        out_data,
    output logic                           out_last,
    output logic                           busy,
    output logic                           err,
    output logic [2:0]                     cp_operacao,
    output logic [WIDTH-1:0]               cp_escalar,
    output logic [N*N*WIDTH-1:0]           cp_A,
    output logic [N*N*WIDTH-1:0]           cp_B,
    input  logic [N*N*res_w(WIDTH)-1:0]    cp_resultado,
    input  logic [det_w(WIDTH)-1:0]        cp_det
);

    localparam int c_NN    = N * N;
    localparam int c_IDX_W = $clog2(c_NN + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX    = c_IDX_W'(c_NN - 1);
    localparam logic [3:0]         c_SETTLE_LAST = 4'(SETTLE - 1);

`ifdef COPROC_SEQ_SKIP_B_EN
    localparam logic c_SKIP_B_EN = 1'b1;
`else
    localparam logic c_SKIP_B_EN = 1'b0;
`endif

    function automatic logic op_skips_b(input logic [2:0] op);
        return c_SKIP_B_EN && ((op == OP_SMUL) || (op == OP_TRANSP) ||
                               (op == OP_OPP)  || (op == OP_DET));
    endfunction

    state_t               state_q, state_d;
    logic [c_IDX_W-1:0]   idx_q;
    logic [3:0]           settle_q;
    logic                 err_q;
    logic [2:0]           cp_operacao_q;
    logic [WIDTH-1:0]     cp_escalar_q;
    logic [c_NN*WIDTH-1:0] cp_a_q, cp_b_q;

    logic cmd_accept, in_xfer, idx_last, settle_done, capture, ob_last;
    logic [det_w(WIDTH)-1:0] ob_data;

    assign cmd_accept  = cmd_valid && cmd_ready;
    assign in_xfer     = in_valid && in_ready;
    assign idx_last    = (idx_q == c_LAST_IDX);
    assign settle_done = (settle_q == c_SETTLE_LAST);
    assign capture     = (state_q == S_EXEC) && settle_done;

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid && (cmd_op != OP_ILLEGAL))
                    state_d = S_LOAD_A;
            end
            S_LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid && idx_last)
                    state_d = op_skips_b(cp_operacao_q) ? S_EXEC : S_LOAD_B;
            end
            S_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid && idx_last)
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                if (settle_done)
                    state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready && ob_last)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            settle_q      <= '0;
            err_q         <= 1'b0;
            cp_operacao_q <= '0;
            cp_escalar_q  <= '0;
            cp_a_q        <= '0;
            cp_b_q        <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_accept) begin
                if (cmd_op == OP_ILLEGAL) begin
                    err_q <= 1'b1;
                end else begin
                    err_q         <= 1'b0;
                    cp_operacao_q <= cmd_op;
                    cp_escalar_q  <= cmd_escalar;
                    if (op_skips_b(cmd_op))
                        cp_b_q <= '0;
                end
            end
            // Elements land straight in the coprocessor operand registers
            if (in_xfer) begin
                if (state_q == S_LOAD_A)
                    cp_a_q[(c_NN - int'(idx_q))*WIDTH - 1 -: WIDTH] <= in_data;
                else
                    cp_b_q[(c_NN - int'(idx_q))*WIDTH - 1 -: WIDTH] <= in_data;
                idx_q <= idx_last ? '0 : idx_q + 1'b1;
            end
            settle_q <= ((state_q == S_EXEC) && !settle_done) ? settle_q + 1'b1 : '0;
        end
    end

    coproc_seq_outbuf #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_outbuf (
        .clk_i      (CLOCK_50),
        .rst_i      (reset),
        .capture_i  (capture),
        .advance_i  (out_valid && out_ready),
        .det_mode_i (cp_operacao_q == OP_DET),
        .res_i      (cp_resultado),
        .det_i      (cp_det),
        .data_o     (ob_data),
        .last_o     (ob_last)
    );

    assign out_data    = ob_data;
    assign out_last    = (state_q == S_OUT) && ob_last;
    assign err         = err_q;
    assign cp_operacao = cp_operacao_q;
    assign cp_escalar  = cp_escalar_q;
    assign cp_A        = cp_a_q;
    assign cp_B        = cp_b_q;

endmodule

`default_nettype wire

// File: tb/tb_coproc_sequencer.sv
// ============================================================================
// Module      : tb_coproc_sequencer
// Description : Scoreboard bench for coproc_sequencer with a behavioural
//               coprocessor model; honours COPROC_SEQ_SKIP_B_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_coproc_sequencer;

    localparam int N = 3, W = 8, SETTLE = 2, RW = 19, DW = 25;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid, cmd_ready, in_valid, in_ready;
    logic            out_valid, out_ready, out_last, busy, err;
    logic [2:0]      cmd_op, cp_operacao;
    logic [W-1:0]    cmd_escalar, in_data, cp_escalar;
    logic [DW-1:0]   out_data, cp_det;
    logic [9*W-1:0]  cp_A, cp_B;
    logic [9*RW-1:0] cp_resultado;

    always #5 clk = ~clk;

    coproc_sequencer #(.N(N), .WIDTH(W), .SETTLE(SETTLE)) dut (
        .CLOCK_50(clk), .reset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_escalar(cmd_escalar),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err),
        .cp_operacao(cp_operacao), .cp_escalar(cp_escalar), .cp_A(cp_A), .cp_B(cp_B),
        .cp_resultado(cp_resultado), .cp_det(cp_det)
    );

    // ---------------- behavioural coprocessor ----------------
    function automatic int el(input logic [9*W-1:0] m, input int i, input int j);
        logic signed [W-1:0] v;
        v = m[(9 - (3*i + j))*W - 1 -: W];
        return int'(v);
    endfunction

    function automatic logic [9*RW-1:0] copro(input logic [2:0] op, input logic [W-1:0] s,
                                               input logic [9*W-1:0] a, input logic [9*W-1:0] b);
        logic [9*RW-1:0] res;
        logic signed [W-1:0] ss;
        int r;
        res = '0;
        ss  = s;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                case (op)
                    3'd0: r = el(a, i, j) + el(b, i, j);
                    3'd1: r = el(a, i, j) - el(b, i, j);
                    3'd2: r = el(a, i, 0)*el(b, 0, j) + el(a, i, 1)*el(b, 1, j) + el(a, i, 2)*el(b, 2, j);
                    3'd3: r = int'(ss) * el(a, i, j);
                    3'd4: r = el(a, j, i);
                    3'd5: r = -el(a, i, j);
                    default: r = 0;
                endcase
                res[(9 - (3*i + j))*RW - 1 -: RW] = RW'(r);
            end
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] det3(input logic [9*W-1:0] a);
        int d;
        d = el(a,0,0)*(el(a,1,1)*el(a,2,2) - el(a,1,2)*el(a,2,1))
          - el(a,0,1)*(el(a,1,0)*el(a,2,2) - el(a,1,2)*el(a,2,0))
          + el(a,0,2)*(el(a,1,0)*el(a,2,1) - el(a,1,1)*el(a,2,0));
        return DW'(d);
    endfunction

    assign cp_resultado = copro(cp_operacao, cp_escalar, cp_A, cp_B);
    assign cp_det       = det3(cp_A);

    // ---------------- scoreboard ----------------
    typedef struct packed { logic l; logic [DW-1:0] d; } exp_t;
    exp_t sb[$];
    int   n_pass = 0, n_total = 0;
    int   ma[9], mb[9], mexp[9];

    task automatic check(input string nm, input logic [71:0] act, input logic [71:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    endtask

    task automatic push9();
        exp_t e;
        for (int k = 0; k < 9; k++) begin
            e.d = DW'(mexp[k]);
            e.l = (k == 8);
            sb.push_back(e);
        end
    endtask

    // Monitor: pops on every accepted word and checks hold-stability under stall
    logic [DW-1:0] hold_d;
    logic          hold_l;
    bit            have_hold = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (out_ready) begin
                have_hold = 1'b0;
                check("word_pending", 72'(sb.size() > 0), 72'(1));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("out_data", 72'(out_data), 72'(e.d));
                    check("out_last", 72'(out_last), 72'(e.l));
                end
            end else begin
                if (have_hold)
                    check("stall_stable", 72'({out_last, out_data}), 72'({hold_l, hold_d}));
                hold_d    = out_data;
                hold_l    = out_last;
                have_hold = 1'b1;
            end
        end else begin
            have_hold = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic bit skip_b(input logic [2:0] op);
`ifdef COPROC_SEQ_SKIP_B_EN
        return op inside {3'd3, 3'd4, 3'd5, 3'd6};
`else
        return (op == 3'd7) && (op != 3'd7);
`endif
    endfunction

    task automatic send_cmd(input logic [2:0] op, input logic [W-1:0] esc);
        cmd_op = op; cmd_escalar = esc; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic load9(input bit use_b);
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1;
            in_data  = use_b ? W'(mb[k]) : W'(ma[k]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_first();
        int n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        // cycles from the last load transfer (inclusive) to the first valid word
        check("latency", 72'(n + 1), 72'(SETTLE + 1));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("back_to_idle", 72'(cmd_ready), 72'(1));
        check("sb_drained", 72'(sb.size()), 72'(0));
    endtask

    task automatic run(input logic [2:0] op, input logic [W-1:0] esc);
        send_cmd(op, esc);
        load9(1'b0);
        if (!skip_b(op)) load9(1'b1);
        wait_first();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cmd_op = '0; cmd_escalar = '0; in_data = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_cmd_ready", 72'(cmd_ready), 72'(1));
        check("rst_busy",      72'(busy),      72'(0));
        check("rst_in_ready",  72'(in_ready),  72'(0));
        check("rst_out_valid", 72'(out_valid), 72'(0));
        check("rst_out_last",  72'(out_last),  72'(0));
        check("rst_out_data",  72'(out_data),  72'(0));
        check("rst_err",       72'(err),       72'(0));
        check("rst_cp_op",     72'(cp_operacao), 72'(0));
        check("rst_cp_esc",    72'(cp_escalar),  72'(0));
        check("rst_cp_A",      72'(cp_A),        72'(0));
        check("rst_cp_B",      72'(cp_B),        72'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Add: A=1..9, B=9..1 -> nine words of 10
        ma = '{1,2,3,4,5,6,7,8,9}; mb = '{9,8,7,6,5,4,3,2,1};
        mexp = '{10,10,10,10,10,10,10,10,10}; push9();
        send_cmd(3'd0, 8'd0); load9(1'b0); load9(1'b1);
        check("cp_A_layout", 72'(cp_A), 72'h010203040506070809);
        check("cp_B_layout", 72'(cp_B), 72'h090807060504030201);
        wait_first();
        repeat (8) @(posedge clk); #1;
        check("add_last_flag", 72'({out_valid, out_last}), 72'(3));
        @(posedge clk); #1;
        check("add_cmd_ready_next", 72'(cmd_ready), 72'(1));
        check("add_busy_low", 72'(busy), 72'(0));

        // Sub with a 5-cycle stall on word 3
        mb = '{2,4,6,8,10,12,14,16,18};
        mexp = '{-1,-2,-3,-4,-5,-6,-7,-8,-9}; push9();
        run(3'd1, 8'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();

        // Mul: A*A
        mb = '{1,2,3,4,5,6,7,8,9};
        mexp = '{30,36,42,66,81,96,102,126,150}; push9();
        run(3'd2, 8'd0); wait_idle();

        // Scalar-mul by -2
        ma = '{5,1,2,3,4,5,6,7,8}; mb = '{0,0,0,0,0,0,0,0,0};
        mexp = '{-10,-2,-4,-6,-8,-10,-12,-14,-16}; push9();
        run(3'd3, 8'hFE);
        check("smul_first_word", 72'(out_data), 72'h1FFFFF6);
        check("cp_B_zero_smul", 72'(cp_B), 72'(0));
        wait_idle();

        // Transpose
        ma = '{1,2,3,4,5,6,7,8,9};
        mexp = '{1,4,7,2,5,8,3,6,9}; push9();
        run(3'd4, 8'd0); wait_idle();

        // Determinant of diag(2,3,4)
        ma = '{2,0,0,0,3,0,0,0,4};
        sb.push_back('{l: 1'b1, d: DW'(24)});
        send_cmd(3'd6, 8'd0); load9(1'b0);
        check("in_ready_after_A", 72'(in_ready), 72'(skip_b(3'd6) ? 0 : 1));
        if (!skip_b(3'd6)) load9(1'b1);
        wait_first(); wait_idle();

        // Illegal opcode, stray in_valid, then a legal op with cmd_valid held while busy
        send_cmd(3'd7, 8'd0);
        check("illegal_err", 72'(err), 72'(1));
        check("illegal_stays_idle", 72'({cmd_ready, busy, in_ready}), 72'(3'b100));
        in_valid = 1'b1; in_data = 8'd77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("stray_in_ignored", 72'(busy), 72'(0));
        ma = '{1,2,3,4,5,6,7,8,9};
        mexp = '{-1,-2,-3,-4,-5,-6,-7,-8,-9}; push9();
        send_cmd(3'd5, 8'd0);
        check("legal_clears_err", 72'(err), 72'(0));
        check("legal_enters_load", 72'({busy, in_ready}), 72'(3));
        cmd_valid = 1'b1; cmd_op = 3'd7;
        load9(1'b0);
        if (!skip_b(3'd5)) load9(1'b1);
        cmd_valid = 1'b0;
        check("busy_cmd_ignored", 72'(err), 72'(0));
        wait_first(); wait_idle();

        // Reset after 4 A transfers, then a full add restarts at element 0
        send_cmd(3'd0, 8'd0);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 8'(100 + k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1; #1;
        check("midload_rst_busy", 72'({busy, in_ready, cmd_ready}), 72'(3'b001));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        mb = '{9,8,7,6,5,4,3,2,1};
        mexp = '{10,10,10,10,10,10,10,10,10}; push9();
        run(3'd0, 8'd0); wait_idle();

        // Reset while a word is pending: nothing may be emitted afterwards
        out_ready = 1'b0;
        send_cmd(3'd4, 8'd0); load9(1'b0);
        if (!skip_b(3'd4)) load9(1'b1);
        wait_first();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; #1;
        check("midout_rst_outs", 72'({out_valid, out_last, out_data}), 72'(0));
        check("midout_rst_cp_A", 72'(cp_A), 72'(0));
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("no_word_after_rst", 72'({out_valid, busy}), 72'(0));

        check("final_sb_empty", 72'(sb.size()), 72'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
